// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: access size encodings and controller state codes shared with the load/store stage
package ram_ctrl_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BEAT0 = 3'd1;
  localparam logic [2:0] ST_BEAT1 = 3'd2;
  localparam logic [2:0] ST_CAP   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;
endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: turns one CPU load/store request into byte beats on a dual-port RAM and returns a response
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic [DATA_W-1:0] ram_wdata_1,
  output logic [DATA_W-1:0] ram_wdata_2,
  output logic              ram_r_w_1,
  output logic              ram_r_w_2,
  input  logic [DATA_W-1:0] ram_rdata_1,
  input  logic [DATA_W-1:0] ram_rdata_2
);
  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              beat, hi;
  logic [ADDR_W-1:0] base;
  // next-state, request capture and read-data assembly
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = req_size == SIZE_ILL;
        state_d = req_size == SIZE_ILL ? ST_RESP : ST_BEAT0;
      end
      ST_BEAT0: state_d = size_q == SIZE_WORD ? ST_BEAT1 : (we_q ? ST_RESP : ST_CAP);
      ST_BEAT1: begin
        if (!we_q) rdata_d[15:0] = {ram_rdata_2, ram_rdata_1};
        state_d = we_q ? ST_RESP : ST_CAP;
      end
      ST_CAP: begin
        rdata_d = size_q == SIZE_WORD ? {ram_rdata_2, ram_rdata_1, rdata_q[15:0]} :
                  size_q == SIZE_HALF ? {16'h0, ram_rdata_2, ram_rdata_1} :
                                        {24'h0, ram_rdata_1};
        state_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // RAM pins decoded only from registered state and request; zero outside beats
  always_comb begin
    beat        = state_q == ST_BEAT0 || state_q == ST_BEAT1;
    hi          = state_q == ST_BEAT1;
    base        = addr_q + (hi ? ADDR_W'(2) : ADDR_W'(0));
    ram_en      = beat;
    ram_addr_1  = beat ? base : '0;
    ram_addr_2  = beat ? base + ADDR_W'(1) : '0;
    ram_wdata_1 = beat ? (hi ? wdata_q[23:16] : wdata_q[7:0]) : '0;
    ram_wdata_2 = beat ? (hi ? wdata_q[31:24] : wdata_q[15:8]) : '0;
    ram_r_w_1   = beat & we_q;
    ram_r_w_2   = beat & we_q & (size_q != SIZE_BYTE);
    req_ready   = state_q == ST_IDLE && !rst;
    rsp_valid   = state_q == ST_RESP;
    rsp_rdata   = rsp_valid ? rdata_q : '0;
    rsp_err     = rsp_valid & err_q;
  end
  // state and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule
